// File: rtl/rename_feed_queue_pkg.sv
// Shared types and helpers for the decode-to-rename feed queue.
// Lane masks are widened to LANE_MAX before calling the helpers.
package rename_feed_queue_pkg;

  localparam int L_ADDR    = 5;
  localparam int PAYLOAD_W = 32;
  localparam int LANE_MAX  = 8;

  typedef enum logic {
    FILL,
    PAD
  } fe_state_t;

  typedef struct packed {
    logic [L_ADDR-1:0]    l_dst;
    logic [PAYLOAD_W-1:0] payload;
  } lane_t;

  function automatic int unsigned popcount(
    input logic [LANE_MAX-1:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < LANE_MAX; i++)
      c += 32'(v[i]);
    return c;
  endfunction

  // A mask is contiguous from lane 0 when mask+1 is a power of two.
  function automatic logic is_contiguous(
    input logic [LANE_MAX-1:0] v
  );
    logic [LANE_MAX-1:0] inc;
    inc = v + LANE_MAX'(1);
    return (v & inc) == '0;
  endfunction

endpackage

// File: rtl/rename_feed_ram.sv
// Circular entry storage: one write and one read port per lane.
// Addresses are base+lane and wrap naturally at DEPTH.
module rename_feed_ram
  import rename_feed_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int INSTR_COUNT = 2,
  localparam int PTRW       = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic [INSTR_COUNT-1:0]        we,
  input  logic [PTRW-1:0]               waddr,
  input  lane_t [INSTR_COUNT-1:0]       wdata,
  input  logic [PTRW-1:0]               raddr,
  output lane_t [INSTR_COUNT-1:0]       rdata
);

  lane_t mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < INSTR_COUNT; i++)
      if (we[i])
        mem[waddr + PTRW'(i)] <= wdata[i];
  end

  always_comb begin
    for (int i = 0; i < INSTR_COUNT; i++)
      rdata[i] = mem[raddr + PTRW'(i)];
  end

endmodule

// File: rtl/rename_feed_queue.sv
// Decoded-instruction queue feeding lane-aligned bundles to rename.
// Starved partial bundles are padded after PAD_TIMEOUT cycles.
module rename_feed_queue
  import rename_feed_queue_pkg::*;
#(
  parameter int INSTR_COUNT = 2,
  parameter int L_REGISTERS = 32,
  parameter int DEPTH       = 8,
  parameter int PAYLOAD_W   = 32,
  parameter int PAD_TIMEOUT = 4,
  localparam int LA         = $clog2(L_REGISTERS),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INSTR_COUNT-1:0]              in_valid,
  input  logic [INSTR_COUNT-1:0][LA-1:0]      in_l_dst,
  input  logic [INSTR_COUNT-1:0][PAYLOAD_W-1:0] in_payload,
  output logic                                in_ready,
  input  logic                                flush,
  input  logic                                stall,
  output logic                                inst_en,
  output logic                                l_dst_valid,
  output logic [INSTR_COUNT-1:0][LA-1:0]      l_dst,
  output logic [INSTR_COUNT-1:0]              lane_valid,
  output logic [INSTR_COUNT-1:0][PAYLOAD_W-1:0] out_payload,
  output logic [CW-1:0]                       occupancy
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int PCW  = $clog2(PAD_TIMEOUT) + 1;

  fe_state_t state_q, state_d;
  logic [PTRW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [PCW-1:0] pad_q, pad_d;
  logic [CW-1:0] n_push, n_pop;
  logic [INSTR_COUNT-1:0] we;
  logic push, pop, starve;
  lane_t [INSTR_COUNT-1:0] wr_lane, rd_lane;

  assign in_ready = !rst && !flush &&
                    (count_q <= CW'(DEPTH - INSTR_COUNT));
  assign push   = in_ready && (|in_valid);
  assign n_push = push ? CW'(popcount(LANE_MAX'(in_valid))) : '0;
  assign we     = in_ready ? in_valid : '0;

  always_comb begin
    for (int i = 0; i < INSTR_COUNT; i++) begin
      wr_lane[i].l_dst   = in_l_dst[i];
      wr_lane[i].payload = in_payload[i];
    end
  end

  rename_feed_ram #(
    .DEPTH      (DEPTH),
    .INSTR_COUNT(INSTR_COUNT)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(tail_q),
    .wdata(wr_lane),
    .raddr(head_q),
    .rdata(rd_lane)
  );

  // Starvation: a partial bundle sits with nothing arriving behind it.
  assign starve = (state_q == FILL) && (count_q != '0) &&
                  (count_q < CW'(INSTR_COUNT)) && (n_push == '0);

  always_comb begin
    state_d    = state_q;
    inst_en    = 1'b0;
    lane_valid = '0;
    n_pop      = '0;
    unique case (state_q)
      FILL: begin
        inst_en = count_q >= CW'(INSTR_COUNT);
        if (inst_en)
          lane_valid = '1;
        n_pop = CW'(INSTR_COUNT);
        if (starve && pad_q == PCW'(PAD_TIMEOUT - 1))
          state_d = PAD;
      end
      PAD: begin
        inst_en = 1'b1;
        for (int i = 0; i < INSTR_COUNT; i++)
          lane_valid[i] = CW'(i) < count_q;
        n_pop = count_q;
      end
    endcase
    if (rst || flush) begin
      inst_en    = 1'b0;
      lane_valid = '0;
    end
    pop = inst_en && !stall && !flush;
    // A push withdraws the padded bundle so the new entries can fill it.
    if (state_q == PAD && (pop || push))
      state_d = FILL;
    pad_d   = starve ? pad_q + PCW'(1) : '0;
    count_d = count_q + n_push - (pop ? n_pop : '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= FILL;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_q + PTRW'(pop ? n_pop : '0);
      tail_q  <= tail_q + PTRW'(n_push);
      count_q <= count_d;
      pad_q   <= pad_d;
    end
  end

  always_comb begin
    for (int i = 0; i < INSTR_COUNT; i++) begin
      l_dst[i]       = lane_valid[i] ? rd_lane[i].l_dst : '0;
      out_payload[i] = lane_valid[i] ? rd_lane[i].payload : '0;
    end
  end

  assign l_dst_valid = inst_en;
  assign occupancy   = count_q;

  a_count: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));
  a_pop: assert property (@(posedge clk) disable iff (rst)
    pop |-> inst_en);
  a_lanes: assert property (@(posedge clk) disable iff (rst)
    is_contiguous(LANE_MAX'(lane_valid)));
  a_in_contig: assert property (@(posedge clk) disable iff (rst)
    is_contiguous(LANE_MAX'(in_valid)))
    else $error("in_valid not contiguous from lane 0");
  a_drop: assert property (@(posedge clk) disable iff (rst || flush)
    !(|in_valid) || in_ready)
    else $warning("push lanes dropped while queue not ready");

endmodule

// File: tb/tb_rename_feed_queue.sv
// Scoreboard bench for rename_feed_queue: directed scenarios then
// random traffic against a queue-level reference model.
module tb_rename_feed_queue;

  localparam int IC    = 2;
  localparam int DEPTH = 8;
  localparam int PT    = 4;
  localparam int LA    = 5;
  localparam int PW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic stall = 1'b0;
  logic [IC-1:0] in_valid = '0;
  logic [IC-1:0][LA-1:0] in_l_dst = '0;
  logic [IC-1:0][PW-1:0] in_payload = '0;
  logic in_ready, inst_en, l_dst_valid;
  logic [IC-1:0][LA-1:0] l_dst;
  logic [IC-1:0] lane_valid;
  logic [IC-1:0][PW-1:0] out_payload;
  logic [CW-1:0] occupancy;

  rename_feed_queue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_l_dst   (in_l_dst),
    .in_payload (in_payload),
    .in_ready   (in_ready),
    .flush      (flush),
    .stall      (stall),
    .inst_en    (inst_en),
    .l_dst_valid(l_dst_valid),
    .l_dst      (l_dst),
    .lane_valid (lane_valid),
    .out_payload(out_payload),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LA-1:0] d;
    logic [PW-1:0] p;
  } ent_t;

  ent_t sb[$];
  int total = 0;
  int bad = 0;
  bit run = 1'b0;
  int starve = 0;
  bit padmode = 1'b0;
  bit e_inst, e_ready, e_pop;
  int e_nreal = 0;
  int e_occ = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Driver plus model: the queue is an ordered list of accepted
  // entries; bundles take the oldest entries; padding after PT starved cycles.
  task automatic cycle(input logic [IC-1:0] v, input logic [LA-1:0] d0,
                       input logic [LA-1:0] d1, input logic st,
                       input logic fl, input logic r);
    int sz, np;
    logic [PW-1:0] p0, p1;
    p0 = $urandom;
    p1 = $urandom;
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_l_dst[0] = d0;
    in_l_dst[1] = d1;
    in_payload[0] = p0;
    in_payload[1] = p1;
    stall = st;
    flush = fl;
    #1;
    sz = sb.size();
    e_occ = r ? 0 : sz;
    e_ready = !r && !fl && (DEPTH - sz >= IC);
    if (r || fl) begin
      e_inst = 1'b0;
      e_nreal = 0;
    end else if (padmode) begin
      e_inst = 1'b1;
      e_nreal = sz;
    end else begin
      e_inst = sz >= IC;
      e_nreal = IC;
    end
    e_pop = e_inst && !st;
    np = 0;
    if (e_ready)
      for (int i = 0; i < IC; i++)
        if (v[i]) np++;
    if (r || fl) begin
      sb.delete();
      starve = 0;
      padmode = 1'b0;
    end else begin
      if (padmode) begin
        if (e_pop || np > 0) padmode = 1'b0;
      end else if (sz > 0 && sz < IC && np == 0) begin
        starve++;
        if (starve == PT) begin
          padmode = 1'b1;
          starve = 0;
        end
      end else begin
        starve = 0;
      end
      if (np > 0) sb.push_back('{d: d0, p: p0});
      if (np > 1) sb.push_back('{d: d1, p: p1});
    end
  endtask

  task automatic idle(input logic st);
    cycle(2'b00, 5'd0, 5'd0, st, 1'b0, 1'b0);
  endtask

  task automatic push2(input logic [LA-1:0] d0, input logic [LA-1:0] d1,
                       input logic st);
    cycle(2'b11, d0, d1, st, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [LA-1:0] d0, input logic st);
    cycle(2'b01, d0, 5'd0, st, 1'b0, 1'b0);
  endtask

  // Monitor: compares the presented bundle against the scoreboard head.
  always @(negedge clk) begin
    if (run) begin
      logic [IC-1:0] elv;
      #2;
      chk("inst_en", 64'(inst_en), 64'(e_inst));
      chk("l_dst_valid", 64'(l_dst_valid), 64'(e_inst));
      chk("in_ready", 64'(in_ready), 64'(e_ready));
      chk("occupancy", 64'(occupancy), 64'(e_occ));
      elv = e_inst ? IC'((1 << e_nreal) - 1) : '0;
      chk("lane_valid", 64'(lane_valid), 64'(elv));
      if (e_inst) begin
        for (int i = 0; i < IC; i++) begin
          if (i >= e_nreal) begin
            chk("pad_l_dst", 64'(l_dst[i]), 64'd0);
            chk("pad_payload", 64'(out_payload[i]), 64'd0);
          end else if (i < sb.size()) begin
            chk("l_dst", 64'(l_dst[i]), 64'(sb[i].d));
            chk("payload", 64'(out_payload[i]), 64'(sb[i].p));
          end else begin
            total++;
            bad++;
            $display("FAIL sb_underflow at %0t: lane %0d", $time, i);
          end
        end
        if (e_pop)
          repeat (e_nreal) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [IC-1:0] v;
    repeat (2) @(posedge clk);
    run = 1'b1;
    cycle(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    // first push and pop
    push2(5'd3, 5'd5, 1'b0);
    idle(1'b0);
    idle(1'b0);
    // fill to full while stalled, drop one push, then drain
    for (int i = 0; i < 4; i++)
      push2(5'(2 * i + 10), 5'(2 * i + 11), 1'b1);
    push2(5'd30, 5'd31, 1'b1);
    idle(1'b1);
    repeat (5) idle(1'b0);
    // single entry padded after starvation
    push1(5'd7, 1'b0);
    repeat (6) idle(1'b0);
    // padded bundle withdrawn by a later push
    push1(5'd7, 1'b1);
    repeat (5) idle(1'b1);
    push1(5'd9, 1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    // flush with occupancy 5 and simultaneous push/pop
    push2(5'd1, 5'd2, 1'b1);
    push2(5'd3, 5'd4, 1'b1);
    push1(5'd6, 1'b1);
    cycle(2'b11, 5'd8, 5'd9, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    // wrap-around streaming
    for (int i = 0; i < 20; i++)
      push2(5'(i), 5'(i + 16), 1'b0);
    repeat (3) idle(1'b0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0, 1: v = 2'b00;
        2: v = 2'b01;
        default: v = 2'b11;
      endcase
      cycle(v, 5'($urandom), 5'($urandom),
            $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 2, 1'b0);
    end
    repeat (8) idle(1'b0);
    @(negedge clk);
    #3;
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_feed_queue.md
Name: rename_feed_queue

Overview:
- Decoded-instruction queue directly upstream of the renaming stage.
- Accepts up to INSTR_COUNT decoded instructions per cycle from decode and buffers them.
- Presents INSTR_COUNT-wide, lane-aligned bundles to renaming (l_dst, l_dst_valid, inst_en) and honours the rename stall.
- Pads a starved partial bundle after a timeout, and flushes on recovery.

Parameters:
- INSTR_COUNT, 2, lanes per bundle (equals the rename width)
- L_REGISTERS, 32, logical registers; the l_dst width is $clog2(L_REGISTERS)
- DEPTH, 8, queue entries; must be a power of two and >= 2*INSTR_COUNT
- PAYLOAD_W, 32, opaque per-instruction payload width (opcode, sources, pc tag)
- PAD_TIMEOUT, 4, starvation cycles before a partial bundle is padded; must be >= 1

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, synchronous active-high
- in_valid, in, INSTR_COUNT, decode lane mask; must be contiguous from lane 0
- in_l_dst, in, INSTR_COUNT x $clog2(L_REGISTERS), logical destinations
- in_payload, in, INSTR_COUNT x PAYLOAD_W, per-lane payload
- in_ready, out, 1, queue can accept a full INSTR_COUNT group this cycle
- flush, in, 1, recovery flush (driven from rec_en)
- stall, in, 1, rename stall (the rename stall output)
- inst_en, out, 1, bundle presented
- l_dst_valid, out, 1, bundle destinations valid; equals inst_en
- l_dst, out, INSTR_COUNT x $clog2(L_REGISTERS), bundle destinations
- lane_valid, out, INSTR_COUNT, real (1) vs padded (0) lanes
- out_payload, out, INSTR_COUNT x PAYLOAD_W, bundle payload
- occupancy, out, $clog2(DEPTH+1), current entry count

Behaviour:
- Storage: circular buffer with head/tail pointers of width $clog2(DEPTH) that wrap naturally, plus a count register.
- Bundle output is read combinationally from head..head+INSTR_COUNT-1 (modulo DEPTH).
- in_ready = !rst && !flush && (DEPTH - count >= INSTR_COUNT). It is evaluated on pre-pop count; same-cycle pop does not extend room.
- Push: when in_ready, write lanes set in in_valid to tail..tail+n-1, and tail += n (n = popcount of in_valid).
  - Non-contiguous in_valid is an assertion error.
  - Lanes pushed while !in_ready are dropped, and a warning assertion fires.
- FSM with states FILL, PAD.
  - FILL: inst_en = (count >= INSTR_COUNT), and all lane_valid = 1.
  - PAD: inst_en = 1, lane_valid[i] = (i < count); padded lanes drive l_dst = 0 and payload = 0.
  - pad_cnt increments each cycle in FILL with 0 < count < INSTR_COUNT and no push; it clears otherwise.
  - FILL -> PAD when pad_cnt == PAD_TIMEOUT-1 and the increment condition holds; PAD is entered on the next cycle.
  - PAD -> FILL on pop, flush, or any push. On a push, the arriving entries fill the bundle on the following cycle and the padded bundle is withdrawn without popping. This is legal because renaming is not handshaked against withdrawal when stall was high.
  - Dropping PAD in favour of the fill is also allowed, since renaming allocates only when inst_en & ~stall.
- Pop: pop = inst_en && !stall && !flush.
  - Head and count advance by the number of real lanes (INSTR_COUNT in FILL, count in PAD).
  - Padded lanes consume no entries.
  - Simultaneous push and pop: count_next = count + n_push - n_pop.
- Flush: on a flush cycle, head = tail = count = pad_cnt = 0 and the state becomes FILL on the next edge.
  - inst_en is forced 0 during the flush cycle; same-cycle pushes and pops are discarded.
  - Flush has priority over every other event.
- Reset: while rst is high, all of the above registers take the flush values.
  - inst_en = 0, l_dst_valid = 0, lane_valid = 0, occupancy = 0, in_ready = 0.
  - in_ready = 1 on the first cycle after rst deasserts.
  - Storage RAM is not reset.
- Latency: an entry pushed at cycle t is visible on the bundle output at t+1 at the earliest.
- Full: count == DEPTH means in_ready = 0. Empty: count == 0 means inst_en = 0 and no timer activity.
- Assertions:
  - count <= DEPTH.
  - No pop when inst_en == 0.
  - lane_valid is contiguous from lane 0.

Decomposition:
- Shared rename package holds:
  - the fe_state_t enum {FILL, PAD};
  - a per-lane struct { l_dst, payload };
  - the helper functions popcount and is_contiguous.
- One sub-module, rename_feed_ram: a DEPTH x (L_ADDR+PAYLOAD_W) storage with INSTR_COUNT write ports and INSTR_COUNT combinational read ports, with modulo addressing done internally.

Test Plan:
- Reset then a 2-lane push (l_dst 3,5) at cycle 1 -> at cycle 2, inst_en=1, l_dst={5,3}, lane_valid=2'b11, occupancy=2; with stall=0, occupancy=0 at cycle 3.
- Fill to DEPTH=8 with stall=1 -> in_ready=0 at count 8; a push attempt is dropped and occupancy stays 8; with stall released, bundles drain 2 per cycle and in_ready=1 once count <= 6.
- Single-lane push (l_dst 7) then idle, PAD_TIMEOUT=4 -> after 4 starved cycles, inst_en=1, lane_valid=2'b01, l_dst[1]=0; pop leaves occupancy=0.
- Partial entry in PAD, then a push of 1 lane (l_dst 9) while stall=1 -> the next cycle is FILL with lane_valid=2'b11 and l_dst={9,7}.
- Flush asserted with occupancy 5 and a simultaneous push/pop -> the next cycle has occupancy=0, inst_en=0, in_ready=1, and pointers at 0.
- Wrap-around: continuous 2-lane push/pop for 20 cycles with DEPTH=8 -> output order matches input order exactly, and occupancy stays constant at 2.
